reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_DOMAINS, default 4, number of independently released reset domains, legal range 1..16.
REQ-002 Parameter LOCK_CYCLES, default 50, consecutive cycles pll_locked must be sampled high before release starts, minimum 1.
REQ-003 Parameter STAGE_GAP, default 16, cycles between successive domain releases, minimum 1.
REQ-004 clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pll_locked  input  1  PLL lock indication, sampled each edge.
REQ-007 sw_reset_req  input  1  software reset request, level-sampled each edge.
REQ-008 domain_reset  output  NUM_DOMAINS  per-domain active-high reset; bit i released in ascending order.
REQ-009 all_ready  output  1  high when every domain is released.
REQ-010 last_cause  output  2  cause of most recent reset: 0 POR, 1 lock loss, 2 software.
REQ-011 reset_events  output  8  saturating count of non-POR reset events.

Function
REQ-012 All outputs SHALL be registered.
REQ-013 States: WAIT_LOCK, RELEASE, RUN.
REQ-014 WAIT_LOCK: counter increments on each edge with pll_locked=1 and clears to 0 on any edge with pll_locked=0; on the LOCK_CYCLES-th consecutive high sample -> RELEASE with counter and stage index at 0.
REQ-015 RELEASE: counter counts STAGE_GAP edges; on the STAGE_GAP-th edge, clear domain_reset[idx], increment idx, clear counter.
REQ-016 Domain i SHALL deassert exactly LOCK_CYCLES + (i+1)*STAGE_GAP edges after the first edge sampling pll_locked=1, provided lock holds.
REQ-017 On the edge releasing domain NUM_DOMAINS-1: all_ready <= 1, state -> RUN.
REQ-018 RUN: all outputs held; no counter activity.
REQ-019 In RELEASE or RUN, pll_locked=0 or sw_reset_req=1 SHALL, on the next edge: set all domain_reset bits, clear all_ready, clear counter and idx, and go to WAIT_LOCK.
REQ-020 The event in REQ-019 sets last_cause: 1 if pll_locked=0, including when sw_reset_req=1 on the same edge; otherwise 2. reset_events increments, saturating at 255.
REQ-021 sw_reset_req=1 in WAIT_LOCK clears the lock counter; last_cause and reset_events unchanged.
REQ-022 A sw_reset_req held high keeps the block in WAIT_LOCK; it counts as one event only on entry from RELEASE or RUN.
REQ-023 Counter width SHALL be clog2(max(LOCK_CYCLES, STAGE_GAP)+1); idx width clog2(NUM_DOMAINS+1).

Reset
REQ-024 reset=1 on an edge: state WAIT_LOCK, domain_reset all ones, all_ready 0, last_cause 0, reset_events 0, counter 0, idx 0.
REQ-025 reset asserted mid-RELEASE or RUN SHALL yield REQ-024 values on the next edge, overriding all other inputs.

Structure
REQ-026 Shared package reset_seq_pkg SHALL hold the state encoding and the cause codes (CAUSE_POR, CAUSE_LOCK, CAUSE_SW).
REQ-027 The design SHALL be a single module; no sub-module is required.

Verification (defaults N=4, LOCK=50, GAP=16)
REQ-028 Release, at defaults: pll_locked=1 from the first edge after reset -> domain_reset 1110 at edge 66, 1100 at 82, 1000 at 98, 0000 and all_ready=1 at 114.
REQ-029 Lock glitch: pll_locked=0 for 1 cycle at lock count 30 -> count restarts; domain 0 releases 66 edges after lock resumes.
REQ-030 Software reset: 1-cycle sw_reset_req in RUN -> next edge domain_reset=1111, all_ready=0, last_cause=2, reset_events=1; all_ready returns 114 edges later.
REQ-031 Lock loss mid-RELEASE: pll_locked drops after domain 1 is released -> 1111 next edge, last_cause=1; simultaneous pll_locked=0 and sw_reset_req=1 -> last_cause=1.
REQ-032 Saturation: 300 software events -> reset_events=255.
REQ-033 Reset during RELEASE: reset asserted mid-RELEASE -> REQ-024 values on the next edge, last_cause=0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and reset-cause codes.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

endpackage

// File: rtl/reset_sequencer.sv
// Waits for a stable PLL lock, then releases per-domain resets one at a time in
// ascending order, restarting on lock loss or a software request.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int LOCK_CYCLES = 50,
  parameter int STAGE_GAP   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_ready,
  output logic [1:0]             last_cause,
  output logic [7:0]             reset_events
);

  localparam int MAX_COUNT = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
  localparam int CW = $clog2(MAX_COUNT + 1);
  localparam int IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DOMAINS - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   rdy_q, rdy_d;
  logic [1:0]             cause_q, cause_d;
  logic [7:0]             ev_q, ev_d;

  logic abort;
  assign abort = !pll_locked || sw_reset_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    rdy_d   = rdy_q;
    cause_d = cause_q;
    ev_d    = ev_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        // Any unlocked sample or pending software request restarts the lock window.
        if (abort) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RELEASE, ST_RUN: begin
        if (abort) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '1;
          rdy_d   = 1'b0;
          cause_d = !pll_locked ? CAUSE_LOCK : CAUSE_SW;
          if (ev_q != 8'hFF) ev_d = ev_q + 8'd1;
        end else if (state_q == ST_RELEASE) begin
          if (cnt_q == GAP_LAST) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (idx_q == IW'(i)) dom_d[i] = 1'b0;
            end
            idx_d = idx_q + IW'(1);
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              rdy_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
        dom_d   = '1;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '1;
      rdy_q   <= 1'b0;
      cause_q <= CAUSE_POR;
      ev_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      rdy_q   <= rdy_d;
      cause_q <= cause_d;
      ev_q    <= ev_d;
    end
  end

  assign domain_reset = dom_q;
  assign all_ready    = rdy_q;
  assign last_cause   = cause_q;
  assign reset_events = ev_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; expected values are
// hand-computed edge counts from the first lock sample.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       sw_reset_req;
  logic [3:0] domain_reset;
  logic       all_ready;
  logic [1:0] last_cause;
  logic [7:0] reset_events;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(
    .NUM_DOMAINS(4),
    .LOCK_CYCLES(50),
    .STAGE_GAP  (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .sw_reset_req(sw_reset_req),
    .domain_reset(domain_reset),
    .all_ready   (all_ready),
    .last_cause  (last_cause),
    .reset_events(reset_events)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance n rising edges; outputs are then observed 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset        = 1'b1;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    step(2);
    check_val("por_dom",    32'(domain_reset), 32'hF);
    check_val("por_ready",  32'(all_ready),    32'h0);
    check_val("por_cause",  32'(last_cause),   32'h0);
    check_val("por_events", 32'(reset_events), 32'h0);

    // Release timeline: lock from the first edge after reset.
    reset      = 1'b0;
    pll_locked = 1'b1;
    step(65);  check_val("rel_e65",  32'(domain_reset), 32'hF);
    step(1);   check_val("rel_e66",  32'(domain_reset), 32'hE);
    step(15);  check_val("rel_e81",  32'(domain_reset), 32'hE);
    step(1);   check_val("rel_e82",  32'(domain_reset), 32'hC);
    step(16);  check_val("rel_e98",  32'(domain_reset), 32'h8);
    step(15);  check_val("rel_e113_rdy", 32'(all_ready), 32'h0);
    step(1);   check_val("rel_e114", 32'(domain_reset), 32'h0);
    check_val("rel_e114_rdy", 32'(all_ready), 32'h1);
    step(10);  check_val("run_hold_dom", 32'(domain_reset), 32'h0);
    check_val("run_hold_rdy", 32'(all_ready), 32'h1);

    // Software reset from RUN.
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    check_val("sw_dom",    32'(domain_reset), 32'hF);
    check_val("sw_rdy",    32'(all_ready),    32'h0);
    check_val("sw_cause",  32'(last_cause),   32'h2);
    check_val("sw_events", 32'(reset_events), 32'h1);
    step(113); check_val("sw_e113_rdy", 32'(all_ready), 32'h0);
    step(1);   check_val("sw_e114_rdy", 32'(all_ready), 32'h1);

    // Lock loss after domain 1 released.
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
    check_val("sw2_events", 32'(reset_events), 32'h2);
    step(82);  check_val("ll_pre_dom", 32'(domain_reset), 32'hC);
    pll_locked = 1'b0;
    step(1);
    check_val("ll_dom",    32'(domain_reset), 32'hF);
    check_val("ll_cause",  32'(last_cause),   32'h1);
    check_val("ll_events", 32'(reset_events), 32'h3);

    // Simultaneous lock loss and software request: lock loss wins.
    pll_locked = 1'b1;
    step(66);  check_val("both_pre_dom", 32'(domain_reset), 32'hE);
    pll_locked   = 1'b0;
    sw_reset_req = 1'b1;
    step(1);
    check_val("both_cause",  32'(last_cause),   32'h1);
    check_val("both_events", 32'(reset_events), 32'h4);

    // Software request held in WAIT_LOCK: no release, no extra events.
    pll_locked = 1'b1;
    step(100);
    check_val("swhold_dom",    32'(domain_reset), 32'hF);
    check_val("swhold_events", 32'(reset_events), 32'h4);
    check_val("swhold_cause",  32'(last_cause),   32'h1);
    sw_reset_req = 1'b0;
    step(65);  check_val("swrel_e65", 32'(domain_reset), 32'hF);
    step(1);   check_val("swrel_e66", 32'(domain_reset), 32'hE);

    // Reset mid-RELEASE overrides lock loss and software request.
    reset        = 1'b1;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b1;
    step(1);
    check_val("rst_dom",    32'(domain_reset), 32'hF);
    check_val("rst_rdy",    32'(all_ready),    32'h0);
    check_val("rst_cause",  32'(last_cause),   32'h0);
    check_val("rst_events", 32'(reset_events), 32'h0);

    // Lock glitch at count 30 restarts the window.
    reset        = 1'b0;
    sw_reset_req = 1'b0;
    pll_locked   = 1'b1;
    step(30);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(65);  check_val("glitch_e65", 32'(domain_reset), 32'hF);
    step(1);   check_val("glitch_e66", 32'(domain_reset), 32'hE);

    // Saturation: 300 software events, each issued from RELEASE.
    for (int k = 0; k < 300; k++) begin
      sw_reset_req = 1'b1;
      step(1);
      sw_reset_req = 1'b0;
      if (k == 253) check_val("sat_k253", 32'(reset_events), 32'd254);
      if (k == 254) check_val("sat_k254", 32'(reset_events), 32'd255);
      step(50);
    end
    check_val("sat_events", 32'(reset_events), 32'd255);
    check_val("sat_cause",  32'(last_cause),   32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
